// File: rtl/gather_pkg.sv
// Shared types and helpers for the gather credit-return block.
// Flit encodings and buffer allocation fall back to these values when params.svh has not set them.
`ifndef HEAD
`define HEAD 2'd1
`endif
`ifndef BODY
`define BODY 2'd2
`endif
`ifndef TAIL
`define TAIL 2'd3
`endif
`ifndef GATHER_CREDIT_ALLOC
`define GATHER_CREDIT_ALLOC 16
`endif

package gather_pkg;

    typedef enum logic {GR_IDLE, GR_PKT} gr_state_t;

    localparam int CREDIT_W = 32;

    // Payload flits per gather packet: everything except HEAD and TAIL.
    function automatic logic [CREDIT_W-1:0] fc_payload(input int fcpl);
        return CREDIT_W'(fcpl - 2);
    endfunction

endpackage

// File: rtl/gather_credit_return_if.sv
// Ejection-side bundle of the gather credit source: flit/pop inputs and credit/status outputs.
interface gather_credit_return_if;
    import gather_pkg::*;

    logic                fire;
    logic [1:0]          flit_type;
    logic                pop;
    logic [CREDIT_W-1:0] credit_upd;
    logic [CREDIT_W-1:0] occupancy;
    logic                pkt_err;
    logic                ovf_err;

    modport master (
        output fire, flit_type, pop,
        input  credit_upd, occupancy, pkt_err, ovf_err
    );

    modport slave (
        input  fire, flit_type, pop,
        output credit_upd, occupancy, pkt_err, ovf_err
    );

endinterface

// File: rtl/gather_flush_timer.sv
// Counts consecutive pop-free cycles while credit is pending; flush_due once FLUSH_CYC-1 is reached.
// Saturates at that value and restarts on any legal pop or credit emission.
module gather_flush_timer
    import gather_pkg::*;
#(
    parameter int FLUSH_CYC = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_pending_nz,
    input  logic i_pop,
    input  logic i_emit,
    output logic o_flush_due
);

    localparam logic [CREDIT_W-1:0] LAST = CREDIT_W'(FLUSH_CYC - 1);

    logic [CREDIT_W-1:0] r_idle_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle_cnt <= '0;
        end else if (i_pop || i_emit) begin
            r_idle_cnt <= '0;
        end else if (i_pending_nz && (r_idle_cnt != LAST)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign o_flush_due = (r_idle_cnt == LAST);

endmodule

// File: rtl/gather_credit_return.sv
// Gather destination credit source: tracks reassembly occupancy, batches freed credit back to the start node.
// Credit grant appears one cycle after the triggering pop; no backpressure, errors are sticky flags.
module gather_credit_return
    import gather_pkg::*;
#(
    parameter int isDN      = 0,
    parameter int FCpl      = 16,
    parameter int RET_BATCH = 4,
    parameter int FLUSH_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    gather_credit_return_if.slave   bus
);

    localparam bit                  EN      = (isDN != 0);
    localparam logic [CREDIT_W-1:0] BATCH   = CREDIT_W'(RET_BATCH);
    localparam logic [CREDIT_W-1:0] ALLOC   = CREDIT_W'(`GATHER_CREDIT_ALLOC);
    localparam logic [CREDIT_W-1:0] PAYLOAD = fc_payload(FCpl);

    gr_state_t           r_state;
    gr_state_t           w_state_next;
    logic [CREDIT_W-1:0] r_plen;
    logic [CREDIT_W-1:0] r_occupancy;
    logic [CREDIT_W-1:0] r_pending;
    logic [CREDIT_W-1:0] r_credit_upd;
    logic                r_pkt_err;
    logic                r_ovf_err;

    logic                w_frame_err;
    logic                w_plen_clr;
    logic                w_plen_inc;
    logic                w_body;
    logic                w_legal_pop;
    logic                w_bad_pop;
    logic                w_pending_nz;
    logic                w_flush_due;
    logic                w_emit;
    logic [CREDIT_W-1:0] w_occ_next;
    logic [CREDIT_W-1:0] w_pend_next;

    // Framing FSM: state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= GR_IDLE;
        end else if (EN) begin
            r_state <= w_state_next;
        end
    end

    // Framing FSM: next state. A stray HEAD in PKT simply restarts the packet.
    always_comb begin
        w_state_next = r_state;
        if (bus.fire) begin
            case (bus.flit_type)
                `HEAD:   w_state_next = GR_PKT;
                `TAIL:   w_state_next = GR_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Framing FSM: outputs.
    always_comb begin
        w_frame_err = 1'b0;
        w_plen_clr  = 1'b0;
        w_plen_inc  = 1'b0;
        if (bus.fire) begin
            case (bus.flit_type)
                `HEAD: begin
                    w_plen_clr  = 1'b1;
                    w_frame_err = (r_state == GR_PKT);
                end
                `BODY: begin
                    w_plen_inc  = (r_state == GR_PKT);
                    w_frame_err = (r_state == GR_IDLE);
                end
                `TAIL: begin
                    w_frame_err = (r_state == GR_IDLE) || (r_plen != PAYLOAD);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_plen <= '0;
        end else if (EN) begin
            if (w_plen_clr) begin
                r_plen <= '0;
            end else if (w_plen_inc) begin
                r_plen <= r_plen + 1'b1;
            end
        end
    end

    // Payload accounting: BODY counts in any state; pops on an empty buffer are discarded.
    assign w_body       = EN && bus.fire && (bus.flit_type == `BODY);
    assign w_legal_pop  = EN && bus.pop && (r_occupancy != '0);
    assign w_bad_pop    = EN && bus.pop && (r_occupancy == '0);
    assign w_occ_next   = r_occupancy + CREDIT_W'(w_body) - CREDIT_W'(w_legal_pop);
    assign w_pend_next  = r_pending + CREDIT_W'(w_legal_pop);
    assign w_pending_nz = (r_pending != '0);
    assign w_emit       = (w_pend_next >= BATCH)
                       || ((w_pend_next != '0) && w_flush_due && !bus.pop);

    gather_flush_timer #(
        .FLUSH_CYC (FLUSH_CYC)
    ) u_flush_timer (
        .clk          (clk),
        .rstn         (rstn),
        .i_pending_nz (w_pending_nz),
        .i_pop        (w_legal_pop),
        .i_emit       (w_emit),
        .o_flush_due  (w_flush_due)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occupancy  <= '0;
            r_pending    <= '0;
            r_credit_upd <= '0;
            r_pkt_err    <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else if (EN) begin
            r_occupancy <= w_occ_next;
            if (w_emit) begin
                r_credit_upd <= w_pend_next;
                r_pending    <= '0;
            end else begin
                r_credit_upd <= '0;
                r_pending    <= w_pend_next;
            end
            if (w_frame_err) begin
                r_pkt_err <= 1'b1;
            end
            if (w_bad_pop || (w_occ_next > ALLOC)) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign bus.credit_upd = r_credit_upd;
    assign bus.occupancy  = r_occupancy;
    assign bus.pkt_err    = r_pkt_err;
    assign bus.ovf_err    = r_ovf_err;

endmodule
